pixel_packer: RTL and testbench

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/dark_fantasy_pkg.sv | 6 +
 rtl/pixel_packer_if.sv | 10 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/pixel_packer.sv | 68 ++++++
 tb/tb_pixel_packer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dark_fantasy_pkg.sv
// dark_fantasy_pkg: shared widths and burst size for the pixel capture path
package dark_fantasy_pkg;
    localparam int PIX_W = 24;
    localparam int WORD_W = 64;
    localparam int BURST_LEN = 16;
endpackage

// File: rtl/pixel_packer_if.sv
// pixel_packer_if: valid/ready word stream from the packer FIFO to its consumer
interface pixel_packer_if
    import dark_fantasy_pkg::*;
;
    logic wvalid;
    logic wready;
    logic [WORD_W-1:0] wdata;
    modport master(output wvalid, wdata, input wready);
    modport slave(input wvalid, wdata, output wready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy output and synchronous clear
module sync_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign valid = |level;
    assign full = level == LW'(DEPTH);
    assign do_pop = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rptr];
    // pointers wrap naturally; clear wins over any push or pop in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i | clr) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
    // storage array carries no reset; stale entries are hidden by level
    always_ff @(posedge clk_i) begin
        if (do_push & ~clr) mem[wptr] <= din;
    end
endmodule

// File: rtl/pixel_packer.sv
// pixel_packer: packs 24-bit pixels into a little-endian 64-bit word stream behind a FIFO
module pixel_packer
    import dark_fantasy_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int BURST = BURST_LEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     vs_i,
    input  logic                     de_i,
    input  logic [PIX_W-1:0]         data_i,
    output logic                     frame_o,
    output logic                     burst_avail_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    pixel_packer_if.master           w
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = WORD_W + PIX_W - 8;
    logic vs_q, vs_rst, rise, take, push, pop, full;
    logic [2:0] res;
    logic [WORD_W-9:0] acc;
    logic [CW-1:0] cat;
    // vs_rst masks an edge that only looks like one because vs_i was high through reset
    assign rise = vs_i & ~vs_q & ~vs_rst;
    assign take = de_i & en_i & ~rise;
    assign push = take & (res >= 3'd5);
    assign pop = w.wvalid & w.wready;
    assign cat = CW'(acc) | (CW'(data_i) << {res, 3'b000});
    assign burst_avail_o = level_o >= LW'(BURST);
    // residue bytes, frame detection and the sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_q <= 1'b0;
            vs_rst <= vs_i;
            frame_o <= 1'b0;
            ovf_o <= 1'b0;
            res <= '0;
            acc <= '0;
        end else begin
            vs_q <= vs_i;
            vs_rst <= 1'b0;
            frame_o <= rise;
            ovf_o <= ovf_o | (push & full & ~pop);
            if (rise) begin
                res <= '0;
                acc <= '0;
            end else if (take) begin
                res <= res + 3'd3;
                acc <= push ? (WORD_W-8)'(cat[CW-1:WORD_W]) : cat[WORD_W-9:0];
            end
        end
    end
    sync_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr(rise),
        .push(push),
        .pop(pop),
        .din(cat[WORD_W-1:0]),
        .dout(w.wdata),
        .valid(w.wvalid),
        .full(full),
        .level(level_o)
    );
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: scenario tasks plus a byte-stream reference model for pixel_packer
module tb_pixel_packer;
    localparam int DEPTH = 32;
    localparam int BURST = 16;
    logic clk = 0, rst = 1, en = 0, vs = 0, de = 0;
    logic [23:0] data = 0;
    logic frame, burst, ovf;
    logic [5:0] level;
    int tests = 0, fails = 0;
    logic [7:0] mb[$];
    logic [63:0] mw[$];
    logic [63:0] cap[$];
    logic movf = 0, mframe = 0, mvs = 0;
    logic [63:0] ref_w [3] = '{64'h0003000002000001, 64'h0600000500000400, 64'h0000080000070000};

    pixel_packer_if wif();
    pixel_packer #(.DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .vs_i(vs), .de_i(de), .data_i(data),
        .frame_o(frame), .burst_avail_o(burst), .level_o(level), .ovf_o(ovf), .w(wif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // advances one clock, updating the model from the inputs seen at that edge
    task automatic step();
        logic [63:0] wd;
        if (rst) begin
            mb.delete(); mw.delete(); movf = 0; mframe = 0; mvs = vs;
        end else begin
            mframe = vs && !mvs;
            mvs = vs;
            if (mframe) begin
                mb.delete(); mw.delete();
            end else begin
                if (mw.size() > 0 && wif.wready) void'(mw.pop_front());
                if (de && en) begin
                    for (int b = 0; b < 3; b++) mb.push_back(data[8*b +: 8]);
                    if (mb.size() >= 8) begin
                        for (int b = 0; b < 8; b++) wd[8*b +: 8] = mb.pop_front();
                        if (mw.size() < DEPTH) mw.push_back(wd); else movf = 1;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pix(input logic [23:0] d);
        de = 1; data = d; step(); de = 0;
    endtask

    task automatic do_reset();
        rst = 1; de = 0; en = 1; vs = 0; wif.wready = 0;
        step(); step();
        rst = 0;
    endtask

    task automatic run_ref8();
        wif.wready = 1; cap.delete();
        for (int i = 1; i <= 12; i++) begin
            if (i <= 8) pix(24'(i)); else step();
            if (wif.wvalid) cap.push_back(wif.wdata);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (level !== 0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
        tests++; if (wif.wvalid !== 0) begin fails++; $display("FAIL reset_wvalid got %b want 0", wif.wvalid); end
        tests++; if (burst !== 0) begin fails++; $display("FAIL reset_burst got %b want 0", burst); end
        tests++; if (frame !== 0) begin fails++; $display("FAIL reset_frame got %b want 0", frame); end
        tests++; if (ovf !== 0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
    endtask

    task automatic test_pack();
        do_reset();
        run_ref8();
        tests++; if (cap.size() != 3) begin fails++; $display("FAIL pack_count got %0d want 3", cap.size()); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= cap.size() || cap[i] !== ref_w[i]) begin fails++; $display("FAIL pack_word%0d got %h want %h", i, cap[i], ref_w[i]); end
        end
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 1; i <= 48; i++) begin
            pix(24'($urandom));
            tests++; if (level !== 6'(3*i/8)) begin fails++; $display("FAIL burst_level px%0d got %0d want %0d", i, level, 3*i/8); end
            tests++; if (burst !== (3*i/8 >= BURST)) begin fails++; $display("FAIL burst_avail px%0d got %b want %b", i, burst, 3*i/8 >= BURST); end
        end
        tests++; if (level !== 18) begin fails++; $display("FAIL burst_final_level got %0d want 18", level); end
        tests++; if (ovf !== 0) begin fails++; $display("FAIL burst_ovf got %b want 0", ovf); end
    endtask

    task automatic test_overflow();
        logic [63:0] exp[$];
        do_reset();
        for (int i = 0; i < 96; i++) pix(24'($urandom));
        tests++; if (level !== 32) begin fails++; $display("FAIL ovf_level got %0d want 32", level); end
        tests++; if (ovf !== 1) begin fails++; $display("FAIL ovf_flag got %b want 1", ovf); end
        exp = mw;
        wif.wready = 1; cap.delete();
        for (int i = 0; i < 40; i++) begin
            if (wif.wvalid) cap.push_back(wif.wdata);
            step();
        end
        tests++; if (cap.size() != 32) begin fails++; $display("FAIL ovf_drain_count got %0d want 32", cap.size()); end
        for (int i = 0; i < 32; i++) begin
            tests++;
            if (i >= cap.size() || cap[i] !== exp[i]) begin fails++; $display("FAIL ovf_word%0d got %h want %h", i, cap[i], exp[i]); end
        end
        tests++; if (ovf !== 1) begin fails++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    endtask

    task automatic test_frame();
        do_reset();
        for (int i = 0; i < 5; i++) pix(24'($urandom));
        tests++; if (level !== 1) begin fails++; $display("FAIL frame_prelevel got %0d want 1", level); end
        vs = 1; step();
        tests++; if (frame !== 1) begin fails++; $display("FAIL frame_pulse got %b want 1", frame); end
        tests++; if (level !== 0) begin fails++; $display("FAIL frame_level got %0d want 0", level); end
        step();
        tests++; if (frame !== 0) begin fails++; $display("FAIL frame_width got %b want 0", frame); end
        run_ref8();
        tests++; if (cap.size() != 3) begin fails++; $display("FAIL frame_count got %0d want 3", cap.size()); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= cap.size() || cap[i] !== ref_w[i]) begin fails++; $display("FAIL frame_word%0d got %h want %h", i, cap[i], ref_w[i]); end
        end
        vs = 0; step();
    endtask

    task automatic test_collide_en();
        int pops;
        do_reset();
        pix(24'($urandom)); pix(24'($urandom));
        vs = 1; de = 1; data = 24'($urandom); step(); de = 0;
        tests++; if (level !== 0) begin fails++; $display("FAIL collide_level got %0d want 0", level); end
        run_ref8();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= cap.size() || cap[i] !== ref_w[i]) begin fails++; $display("FAIL collide_word%0d got %h want %h", i, cap[i], ref_w[i]); end
        end
        vs = 0; wif.wready = 0;
        for (int i = 0; i < 8; i++) pix(24'($urandom));
        tests++; if (level !== 3) begin fails++; $display("FAIL en_prelevel got %0d want 3", level); end
        en = 0; wif.wready = 1; pops = 0;
        for (int i = 0; i < 10; i++) begin
            if (wif.wvalid) pops++;
            de = 1; data = 24'($urandom); step();
        end
        de = 0; en = 1;
        tests++; if (pops != 3) begin fails++; $display("FAIL en_pops got %0d want 3", pops); end
        tests++; if (level !== 0) begin fails++; $display("FAIL en_level got %0d want 0", level); end
        tests++; if (wif.wvalid !== 0) begin fails++; $display("FAIL en_wvalid got %b want 0", wif.wvalid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 96; i++) pix(24'($urandom));
        wif.wready = 1;
        for (int i = 0; i < 40 && level != 10; i++) step();
        tests++; if (level !== 10) begin fails++; $display("FAIL rstmid_wait got %0d want 10", level); end
        de = 1; rst = 1; step(); rst = 0; de = 0;
        tests++; if (level !== 0) begin fails++; $display("FAIL rstmid_level got %0d want 0", level); end
        tests++; if (wif.wvalid !== 0) begin fails++; $display("FAIL rstmid_wvalid got %b want 0", wif.wvalid); end
        tests++; if (ovf !== 0) begin fails++; $display("FAIL rstmid_ovf got %b want 0", ovf); end
    endtask

    task automatic test_vs_held_reset();
        vs = 1; rst = 1; step(); step(); rst = 0; step();
        tests++; if (frame !== 0) begin fails++; $display("FAIL vsheld_frame0 got %b want 0", frame); end
        step();
        tests++; if (frame !== 0) begin fails++; $display("FAIL vsheld_frame1 got %b want 0", frame); end
        vs = 0; step(); vs = 1; step();
        tests++; if (frame !== 1) begin fails++; $display("FAIL vsheld_rearm got %b want 1", frame); end
        vs = 0; step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 999) == 0;
            de = $urandom_range(0, 9) < 7;
            en = $urandom_range(0, 9) != 0;
            vs = $urandom_range(0, 199) == 0;
            data = 24'($urandom);
            wif.wready = ((c / 400) % 2 == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            step();
            tests++; if (level !== 6'(mw.size())) begin fails++; $display("FAIL rand_level c%0d got %0d want %0d", c, level, mw.size()); end
            tests++; if (wif.wvalid !== (mw.size() != 0)) begin fails++; $display("FAIL rand_wvalid c%0d got %b want %b", c, wif.wvalid, mw.size() != 0); end
            if (mw.size() != 0) begin
                tests++; if (wif.wdata !== mw[0]) begin fails++; $display("FAIL rand_wdata c%0d got %h want %h", c, wif.wdata, mw[0]); end
            end
            tests++; if (burst !== (mw.size() >= BURST)) begin fails++; $display("FAIL rand_burst c%0d got %b want %b", c, burst, mw.size() >= BURST); end
            tests++; if (ovf !== movf) begin fails++; $display("FAIL rand_ovf c%0d got %b want %b", c, ovf, movf); end
            tests++; if (frame !== mframe) begin fails++; $display("FAIL rand_frame c%0d got %b want %b", c, frame, mframe); end
        end
        rst = 0; de = 0; en = 1; vs = 0;
    endtask

    initial begin
        wif.wready = 0;
        test_reset();
        test_pack();
        test_burst();
        test_overflow();
        test_frame();
        test_collide_en();
        test_reset_mid();
        test_vs_held_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
